// File: rtl/pito_irq_router.sv
// pito_irq_router: routes {hart_id, data} events from N_SRC producers into
// per-hart FIFOs. Each hart has a round-robin arbiter over its requesters,
// a level pending flag, the head payload, an ack-driven pop, a sticky
// overflow flag (drop mode) and a shared sticky bad_hart flag.
module pito_irq_router #(
  parameter int NUM_HARTS    = 8,
  parameter int N_SRC        = 8,
  parameter int DATA_W       = 32,
  parameter int Q_DEPTH      = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_SRC-1:0]                        src_valid,
  input  logic [N_SRC*HART_W-1:0]                 src_hart_id,
  input  logic [N_SRC*DATA_W-1:0]                 src_data,
  output logic [N_SRC-1:0]                        src_ready,
  output logic [NUM_HARTS-1:0]                    irq_pending,
  output logic [NUM_HARTS*DATA_W-1:0]             irq_data,
  input  logic [NUM_HARTS-1:0]                    irq_ack,
  output logic [NUM_HARTS*($clog2(Q_DEPTH)+1)-1:0] irq_count,
  output logic [NUM_HARTS-1:0]                    irq_overflow,
  input  logic [NUM_HARTS-1:0]                    ovf_clr,
  output logic                                    bad_hart
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [HART_W:0] NH_LIM = (HART_W+1)'(NUM_HARTS);

  logic [HART_W-1:0] hid       [N_SRC];
  logic [DATA_W-1:0] sdat      [N_SRC];
  logic [N_SRC-1:0]  bad_req;

  logic [SW-1:0]     rr_ptr    [NUM_HARTS];
  logic [PW-1:0]     wp        [NUM_HARTS];
  logic [PW-1:0]     rp        [NUM_HARTS];
  logic [CW-1:0]     cnt       [NUM_HARTS];
  logic [DATA_W-1:0] mem       [NUM_HARTS][Q_DEPTH];

  logic [NUM_HARTS-1:0] gnt, full, push, pop, drop;
  logic [SW-1:0]        gnt_src   [NUM_HARTS];
  logic [DATA_W-1:0]    push_data [NUM_HARTS];

  // Unpack source fields and flag requests addressed to nonexistent harts
  always_comb begin
    for (int unsigned s = 0; s < N_SRC; s++) begin
      hid[s]     = src_hart_id[s*HART_W +: HART_W];
      sdat[s]    = src_data[s*DATA_W +: DATA_W];
      bad_req[s] = src_valid[s] && ({1'b0, hid[s]} >= NH_LIM);
    end
  end

  // Per-hart round-robin search starting at rr_ptr; full uses pre-pop count
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      gnt[h]     = 1'b0;
      gnt_src[h] = '0;
      full[h]    = (cnt[h] == CW'(Q_DEPTH));
      for (int unsigned i = 0; i < N_SRC; i++) begin
        idx = (32'(rr_ptr[h]) + i) % N_SRC;
        if (!gnt[h] && src_valid[idx] && (hid[idx] == HART_W'(h))) begin
          gnt[h]     = 1'b1;
          gnt_src[h] = SW'(idx);
        end
      end
      push[h]      = gnt[h] && !full[h];
      drop[h]      = gnt[h] && full[h] && (DROP_ON_FULL != 0);
      pop[h]       = irq_ack[h] && (cnt[h] != '0);
      push_data[h] = sdat[gnt_src[h]];
    end
  end

  // Handshake: bad-hart requests always consumed, winners consumed unless stalled
  always_comb begin
    src_ready = '0;
    if (!rst) begin
      for (int unsigned s = 0; s < N_SRC; s++)
        src_ready[s] = bad_req[s];
      for (int unsigned h = 0; h < NUM_HARTS; h++)
        if (gnt[h] && (!full[h] || (DROP_ON_FULL != 0)))
          src_ready[gnt_src[h]] = 1'b1;
    end
  end

  // Queue pointers, occupancy, arbiter pointers and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        rr_ptr[h] <= '0;
        wp[h]     <= '0;
        rp[h]     <= '0;
        cnt[h]    <= '0;
      end
      irq_overflow <= '0;
      bad_hart     <= 1'b0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (push[h]) wp[h] <= wp[h] + 1'b1;
        if (pop[h])  rp[h] <= rp[h] + 1'b1;
        cnt[h] <= cnt[h] + CW'(push[h]) - CW'(pop[h]);
        if (gnt[h])
          rr_ptr[h] <= (gnt_src[h] == SW'(N_SRC-1)) ? '0 : gnt_src[h] + 1'b1;
        if (drop[h])         irq_overflow[h] <= 1'b1;
        else if (ovf_clr[h]) irq_overflow[h] <= 1'b0;
      end
      if (|bad_req) bad_hart <= 1'b1;
    end
  end

  // Payload storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    for (int unsigned h = 0; h < NUM_HARTS; h++)
      if (push[h]) mem[h][wp[h]] <= push_data[h];
  end

  // Per-hart status outputs: head payload muxed by read pointer
  always_comb begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      irq_pending[h]               = (cnt[h] != '0);
      irq_data[h*DATA_W +: DATA_W] = (cnt[h] != '0) ? mem[h][rp[h]] : '0;
      irq_count[h*CW +: CW]        = cnt[h];
    end
  end

endmodule

// File: tb/tb_pito_irq_router.sv
// tb_pito_irq_router: two routers (backpressure and drop mode, 6 harts) share
// one stimulus stream; a queue-based reference model predicts both.
module tb_pito_irq_router;

  localparam int NH = 6;
  localparam int NS = 8;
  localparam int DW = 32;
  localparam int QD = 4;
  localparam int HW = 3;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*HW-1:0]  src_hart_id = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NH-1:0]     irq_ack = '0;
  logic [NH-1:0]     ovf_clr = '0;

  logic [NS-1:0]     rdy0, rdy1;
  logic [NH-1:0]     pend0, pend1, ovf0, ovf1;
  logic [NH*DW-1:0]  data0, data1;
  logic [NH*CW-1:0]  cnt0, cnt1;
  logic              bad0, bad1;

  int checks = 0;
  int failures = 0;

  logic [31:0]  mq   [2][NH][$];
  int unsigned  mrr  [2][NH];
  bit           movf [2][NH];
  bit           mbad [2];

  always #5 clk = ~clk;

  pito_irq_router #(.NUM_HARTS(NH), .N_SRC(NS), .DATA_W(DW), .Q_DEPTH(QD), .DROP_ON_FULL(0)) u_bp (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_hart_id(src_hart_id),
    .src_data(src_data), .src_ready(rdy0), .irq_pending(pend0), .irq_data(data0),
    .irq_ack(irq_ack), .irq_count(cnt0), .irq_overflow(ovf0), .ovf_clr(ovf_clr),
    .bad_hart(bad0));

  pito_irq_router #(.NUM_HARTS(NH), .N_SRC(NS), .DATA_W(DW), .Q_DEPTH(QD), .DROP_ON_FULL(1)) u_dr (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_hart_id(src_hart_id),
    .src_data(src_data), .src_ready(rdy1), .irq_pending(pend1), .irq_data(data1),
    .irq_ack(irq_ack), .irq_count(cnt1), .irq_overflow(ovf1), .ovf_clr(ovf_clr),
    .bad_hart(bad1));

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic int unsigned hid_of(int unsigned s);
    logic [HW-1:0] v;
    v = src_hart_id[s*HW +: HW];
    return int'(v);
  endfunction

  task automatic set_src(int unsigned s, bit v, int unsigned hart, logic [31:0] d);
    src_valid[s]          = v;
    src_hart_id[s*HW +: HW] = HW'(hart);
    src_data[s*DW +: DW]  = d;
  endtask

  // Check both DUTs against the model, then advance the model over one edge.
  task automatic tick();
    logic [NS-1:0] er [2];
    int            win [2][NH];
    bit            dopush [2][NH];
    bit            setovf [2][NH];
    bit            anybad;
    logic [NS-1:0] rv;
    logic [NH-1:0] pv, ov;
    logic [NH*DW-1:0] dv;
    logic [NH*CW-1:0] cv;
    logic [31:0]   ed;
    #1;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int h = 0; h < NH; h++) begin
          mq[m][h].delete(); mrr[m][h] = 0; movf[m][h] = 0;
        end
        mbad[m] = 0;
      end
    end
    anybad = 0;
    for (int m = 0; m < 2; m++) begin
      er[m] = '0;
      for (int h = 0; h < NH; h++) begin
        win[m][h] = -1; dopush[m][h] = 0; setovf[m][h] = 0;
      end
      if (!rst) begin
        for (int s = 0; s < NS; s++)
          if (src_valid[s] && hid_of(s) >= NH) begin
            er[m][s] = 1'b1; anybad = 1;
          end
        for (int h = 0; h < NH; h++) begin
          for (int i = 0; i < NS; i++) begin
            int s;
            s = (int'(mrr[m][h]) + i) % NS;
            if (win[m][h] < 0 && src_valid[s] && hid_of(s) == h) win[m][h] = s;
          end
          if (win[m][h] >= 0) begin
            if (mq[m][h].size() < QD) begin
              er[m][win[m][h]] = 1'b1; dopush[m][h] = 1;
            end else if (m == 1) begin
              er[m][win[m][h]] = 1'b1; setovf[m][h] = 1;
            end
          end
        end
      end
      rv = m ? rdy1 : rdy0;  pv = m ? pend1 : pend0;  ov = m ? ovf1 : ovf0;
      dv = m ? data1 : data0; cv = m ? cnt1 : cnt0;
      chk($sformatf("ready[%0d]", m), rv, er[m]);
      chk($sformatf("bad_hart[%0d]", m), m ? bad1 : bad0, mbad[m]);
      for (int h = 0; h < NH; h++) begin
        ed = (mq[m][h].size() > 0) ? mq[m][h][0] : 32'h0;
        chk($sformatf("pending[%0d][%0d]", m, h), pv[h], mq[m][h].size() > 0);
        chk($sformatf("count[%0d][%0d]", m, h), cv[h*CW +: CW], mq[m][h].size());
        chk($sformatf("data[%0d][%0d]", m, h), dv[h*DW +: DW], ed);
        chk($sformatf("overflow[%0d][%0d]", m, h), ov[h], movf[m][h]);
      end
    end
    @(posedge clk);
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int h = 0; h < NH; h++) begin
          if (irq_ack[h] && mq[m][h].size() > 0) void'(mq[m][h].pop_front());
          if (dopush[m][h]) mq[m][h].push_back(src_data[win[m][h]*DW +: DW]);
          if (win[m][h] >= 0) mrr[m][h] = (win[m][h] + 1) % NS;
          if (setovf[m][h]) movf[m][h] = 1;
          else if (ovf_clr[h]) movf[m][h] = 0;
        end
        if (anybad) mbad[m] = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [6];
    order = '{1, 4, 6, 1, 4, 6};
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Fill hart 3 from source 0 with 1..5, no acks
    for (int i = 1; i <= 5; i++) begin
      set_src(0, 1, 3, i);
      if (i == 5) begin
        #1;
        chk("bp_ready_on_full", rdy0[0], 1'b0);
        chk("bp_count_full", cnt0[3*CW +: CW], 3'd4);
      end
      tick();
    end
    irq_ack[3] = 1'b1;
    tick();
    irq_ack[3] = 1'b0;
    #1 chk("bp_accept_after_ack", rdy0[0], 1'b1);
    tick();
    set_src(0, 0, 3, 0);
    irq_ack[3] = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1 chk("bp_drain_order", data0[3*DW +: DW], i);
      tick();
    end
    irq_ack[3] = 1'b0;

    // Reset with three entries queued on hart 2
    for (int i = 0; i < 3; i++) begin
      set_src(1, 1, 2, 32'h10 + i);
      tick();
    end
    set_src(1, 0, 2, 0);
    set_src(0, 1, 0, 32'h77);
    rst = 1'b1;
    #1;
    chk("rst_pending", pend0, '0);
    chk("rst_count", cnt0, '0);
    chk("rst_data", data0, '0);
    chk("rst_ready", rdy0, '0);
    chk("rst_ovf", ovf1, '0);
    tick();
    rst = 1'b0;
    set_src(0, 1, 2, 32'hA5);
    tick();
    set_src(0, 0, 2, 0);
    #1;
    chk("post_rst_pending", pend0[2], 1'b1);
    chk("post_rst_data", data0[2*DW +: DW], 32'hA5);
    irq_ack[2] = 1'b1;
    tick();
    irq_ack[2] = 1'b0;

    // Round-robin on hart 0 with an independent stream to hart 5
    set_src(1, 1, 0, 1); set_src(4, 1, 0, 4); set_src(6, 1, 0, 6);
    set_src(2, 1, 5, 32'h22);
    irq_ack[0] = 1'b1; irq_ack[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", rdy0 & 8'b0101_0010, 8'(1 << order[k]));
      chk("rr_other_hart", rdy0[2], 1'b1);
      tick();
    end
    src_valid = '0;
    tick(); tick();
    irq_ack = '0;

    // Drop mode: overfill hart 1
    for (int i = 0; i < 10; i++) begin
      set_src(3, 1, 1, 32'h100 + i);
      if (i >= 4) begin
        #1 chk("drop_ready", rdy1[3], 1'b1);
      end
      tick();
    end
    set_src(3, 0, 1, 0);
    #1;
    chk("drop_count", cnt1[1*CW +: CW], 3'd4);
    chk("drop_ovf_set", ovf1[1], 1'b1);
    ovf_clr[1] = 1'b1;
    tick();
    #1 chk("ovf_cleared", ovf1[1], 1'b0);
    set_src(3, 1, 1, 32'h1FF);
    tick();
    #1 chk("ovf_set_wins", ovf1[1], 1'b1);
    set_src(3, 0, 1, 0);
    ovf_clr[1] = 1'b0;
    irq_ack[1] = 1'b1;
    repeat (5) tick();
    irq_ack[1] = 1'b0;

    // Ack on empty, bad hart id, push+pop at count 2 across wrap
    irq_ack[4] = 1'b1;
    tick();
    irq_ack[4] = 1'b0;
    #1 chk("ack_empty_count", cnt0[4*CW +: CW], 3'd0);
    set_src(5, 1, 7, 32'hDEAD);
    #1 chk("bad_ready", rdy0[5], 1'b1);
    tick();
    set_src(5, 0, 0, 0);
    #1 chk("bad_sticky", bad0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_src(0, 1, 3, 32'h30 + i);
      tick();
    end
    irq_ack[3] = 1'b1;
    for (int i = 2; i < 7; i++) begin
      set_src(0, 1, 3, 32'h30 + i);
      #1 chk("pushpop_count", cnt0[3*CW +: CW], 3'd2);
      tick();
    end
    set_src(0, 0, 3, 0);
    repeat (3) tick();
    irq_ack = '0;

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++)
        set_src(s, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      for (int h = 0; h < NH; h++) begin
        irq_ack[h] = ($urandom_range(0, 2) == 0);
        ovf_clr[h] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    src_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
